// File: rtl/mem_stage_if.sv
// MEM stage bus bundle: EX-side inputs, load return data, and the WB / forwarding
// / exception outputs. master = upstream driver, slave = the MEM stage itself.
interface mem_stage_if #(
    parameter int STALL_WD = 6
);
    logic                flush;
    logic [STALL_WD-1:0] stall;
    logic [147:0]        ex_to_mem_bus;
    logic [31:0]         data_sram_rdata;
    logic [139:0]        mem_to_wb_bus;
    logic [75:0]         mem_to_rf_bus;
    logic                excp_adel;
    logic [31:0]         excp_pc;

    modport master (
        output flush, stall, ex_to_mem_bus, data_sram_rdata,
        input  mem_to_wb_bus, mem_to_rf_bus, excp_adel, excp_pc
    );

    modport slave (
        input  flush, stall, ex_to_mem_bus, data_sram_rdata,
        output mem_to_wb_bus, mem_to_rf_bus, excp_adel, excp_pc
    );
endinterface

// File: rtl/mem_stage.sv
// Dual-issue MEM stage. Registers the EX bundle, finishes slot1 loads (byte/half
// select and extension), flags misaligned slot1 loads, and drives the WB and
// register-file forwarding buses combinationally from the registered state.
//
// WB slot layout (70 bits): {valid, pc[31:1], we, waddr[4:0], wdata[31:0]}.
// The slot is 70 bits wide, so pc bit 0 is not carried; instruction addresses
// are word aligned, and the full pc of a faulting load is on excp_pc.
module mem_stage #(
    parameter int STALL_WD = 6
) (
    input  logic        clk,
    input  logic        rst,
    mem_stage_if.slave  mif
);
    localparam int MEM_B = 3;
    localparam int WB_B  = 4;

    logic [STALL_WD-1:0] stall_v;
    logic [147:0]        bus_r;
    logic [31:0]         rdata_hold;
    logic                hold_vld;
    logic                stall_mem, stall_wb;

    assign stall_v   = mif.stall;
    assign stall_mem = stall_v[MEM_B];
    assign stall_wb  = stall_v[WB_B];

    // Slot decode: {valid, pc, we, waddr, result, load_op}
    logic        v1, v2, we1, we2;
    logic [31:0] pc1, pc2, res1, res2;
    logic [4:0]  wa1, wa2;
    logic [2:0]  lop1;

    assign {v1, pc1, we1, wa1, res1, lop1} = bus_r[73:0];
    assign {v2, pc2, we2, wa2, res2}       = bus_r[147:3+74];

    // Pipeline register: flush > bubble (MEM stalled, WB moving) > load > hold
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                         bus_r <= '0;
        else if (mif.flush)               bus_r <= '0;
        else if (stall_mem && !stall_wb)  bus_r <= '0;
        else if (!stall_mem)              bus_r <= mif.ex_to_mem_bus;
    end

    // Load data returns once; keep it for the rest of a stall. The flag is
    // dropped whenever bus_r changes (load, bubble or flush).
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rdata_hold <= '0;
            hold_vld   <= 1'b0;
        end else if (mif.flush || !stall_mem || !stall_wb) begin
            hold_vld   <= 1'b0;
        end else if (!hold_vld) begin
            rdata_hold <= mif.data_sram_rdata;
            hold_vld   <= 1'b1;
        end
    end

    // Slot1 load alignment, extension and misalignment detection
    logic [31:0] ld_word, wdata1;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic        misalign, adel;

    always_comb begin
        ld_word = hold_vld ? rdata_hold : mif.data_sram_rdata;
        case (res1[1:0])
            2'd0:    ld_byte = ld_word[7:0];
            2'd1:    ld_byte = ld_word[15:8];
            2'd2:    ld_byte = ld_word[23:16];
            default: ld_byte = ld_word[31:24];
        endcase
        ld_half = res1[1] ? ld_word[31:16] : ld_word[15:0];
        case (lop1)
            3'd1:    wdata1 = {{24{ld_byte[7]}}, ld_byte};
            3'd2:    wdata1 = {24'b0, ld_byte};
            3'd3:    wdata1 = {{16{ld_half[15]}}, ld_half};
            3'd4:    wdata1 = {16'b0, ld_half};
            3'd5:    wdata1 = ld_word;
            default: wdata1 = res1;
        endcase
        misalign = ((lop1 == 3'd3 || lop1 == 3'd4) && res1[0])
                 || (lop1 == 3'd5 && res1[1:0] != 2'b00);
        adel     = v1 && misalign;
    end

    // Output buses: invalid slots are all-zero; a faulting load never writes
    always_comb begin
        logic we1_eff;
        we1_eff = we1 && !adel;
        mif.mem_to_wb_bus = '0;
        mif.mem_to_rf_bus = '0;
        if (v1) begin
            mif.mem_to_wb_bus[69:0] = {1'b1, pc1[31:1], we1_eff, wa1, wdata1};
            mif.mem_to_rf_bus[37:0] = {we1_eff, wa1, wdata1};
        end
        if (v2) begin
            mif.mem_to_wb_bus[139:70] = {1'b1, pc2[31:1], we2, wa2, res2};
            mif.mem_to_rf_bus[75:38]  = {we2, wa2, res2};
        end
        mif.excp_adel = adel;
        mif.excp_pc   = adel ? pc1 : 32'b0;
    end

endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: expected outputs are pushed when an
// instruction is driven and popped when the MEM stage presents it.
module tb_mem_stage;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    mem_stage_if #(.STALL_WD(6)) ifc ();
    mem_stage #(.STALL_WD(6)) dut (.clk(clk), .rst(rst), .mif(ifc.slave));

    typedef struct {
        int           due;
        string        tag;
        logic [139:0] wb;
        logic [75:0]  rf;
        logic         adel;
        logic [31:0]  epc;
    } exp_t;

    typedef struct {
        logic [2:0]  lop;
        logic [31:0] res;
        logic [31:0] rd;
        logic [31:0] wd;
        logic        we;
        logic        adel;
    } vec_t;

    exp_t q[$];
    int   n_chk  = 0;
    int   n_fail = 0;
    int   cyc_n  = 0;

    task automatic check(input string tag, input logic [139:0] obs, input logic [139:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s obs=%h exp=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [73:0] exs(logic [31:0] pc, logic we, logic [4:0] wa,
                                        logic [31:0] res, logic [2:0] lop);
        return {1'b1, pc, we, wa, res, lop};
    endfunction

    function automatic logic [69:0] wbs(logic [31:0] pc, logic we, logic [4:0] wa, logic [31:0] wd);
        return {1'b1, pc[31:1], we, wa, wd};
    endfunction

    task automatic push1(input string tag, input logic [31:0] pc, input logic we,
                         input logic [4:0] wa, input logic [31:0] wd, input logic adel);
        exp_t e;
        logic wee;
        wee    = we & ~adel;
        e.due  = cyc_n + 1;
        e.tag  = tag;
        e.wb   = {70'b0, wbs(pc, wee, wa, wd)};
        e.rf   = {38'b0, wee, wa, wd};
        e.adel = adel;
        e.epc  = adel ? pc : 32'b0;
        q.push_back(e);
    endtask

    task automatic pushz(input string tag, input int due);
        exp_t e;
        e.due = due; e.tag = tag; e.wb = '0; e.rf = '0; e.adel = 1'b0; e.epc = '0;
        q.push_back(e);
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_wb"},   ifc.mem_to_wb_bus, 140'b0);
        check({tag, "_rf"},   {64'b0, ifc.mem_to_rf_bus}, 140'b0);
        check({tag, "_adel"}, {139'b0, ifc.excp_adel}, 140'b0);
        check({tag, "_epc"},  {108'b0, ifc.excp_pc}, 140'b0);
    endtask

    task automatic sample();
        exp_t e;
        while (q.size() > 0 && q[0].due < cyc_n) begin
            e = q.pop_front();
            check({e.tag, "_late"}, 140'(cyc_n), 140'(e.due));
        end
        if (q.size() > 0 && q[0].due == cyc_n) begin
            e = q.pop_front();
            check({e.tag, "_wb"},   ifc.mem_to_wb_bus, e.wb);
            check({e.tag, "_rf"},   {64'b0, ifc.mem_to_rf_bus}, {64'b0, e.rf});
            check({e.tag, "_adel"}, {139'b0, ifc.excp_adel}, {139'b0, e.adel});
            check({e.tag, "_epc"},  {108'b0, ifc.excp_pc}, {108'b0, e.epc});
        end
    endtask

    // One clock: drive on the falling edge, sample before the next rising edge
    task automatic cyc(input logic [147:0] ex, input logic [31:0] rd,
                       input logic [5:0] st, input logic fl);
        @(negedge clk);
        ifc.ex_to_mem_bus   = ex;
        ifc.data_sram_rdata = rd;
        ifc.stall           = st;
        ifc.flush           = fl;
        #2;
        sample();
        cyc_n++;
    endtask

    localparam logic [5:0] ST_HOLD   = 6'b011111;
    localparam logic [5:0] ST_BUBBLE = 6'b001000;

    vec_t tbl[15];

    initial begin
        #200000;
        $display("FAIL watchdog obs=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0]  = '{3'd1, 32'h1003, 32'h80AA55CC, 32'hFFFFFF80, 1'b1, 1'b0};
        tbl[1]  = '{3'd2, 32'h1001, 32'h80AA55CC, 32'h00000055, 1'b1, 1'b0};
        tbl[2]  = '{3'd1, 32'h1000, 32'h80AA55CC, 32'hFFFFFFCC, 1'b1, 1'b0};
        tbl[3]  = '{3'd2, 32'h1002, 32'h80AA55CC, 32'h000000AA, 1'b1, 1'b0};
        tbl[4]  = '{3'd3, 32'h1002, 32'h80AA55CC, 32'hFFFF80AA, 1'b1, 1'b0};
        tbl[5]  = '{3'd4, 32'h1000, 32'h80AA55CC, 32'h000055CC, 1'b1, 1'b0};
        tbl[6]  = '{3'd3, 32'h1000, 32'h00008001, 32'hFFFF8001, 1'b1, 1'b0};
        tbl[7]  = '{3'd5, 32'h1004, 32'hCAFEF00D, 32'hCAFEF00D, 1'b1, 1'b0};
        tbl[8]  = '{3'd0, 32'h12345678, 32'hFFFFFFFF, 32'h12345678, 1'b0, 1'b0};
        tbl[9]  = '{3'd6, 32'h0000ABCD, 32'hFFFFFFFF, 32'h0000ABCD, 1'b1, 1'b0};
        tbl[10] = '{3'd7, 32'h0000ABCE, 32'hFFFFFFFF, 32'h0000ABCE, 1'b1, 1'b0};
        tbl[11] = '{3'd5, 32'h3001, 32'h12345678, 32'h12345678, 1'b1, 1'b1};
        tbl[12] = '{3'd3, 32'h3003, 32'h80000000, 32'hFFFF8000, 1'b1, 1'b1};
        tbl[13] = '{3'd4, 32'h3002, 32'h80000000, 32'h00008000, 1'b1, 1'b0};
        tbl[14] = '{3'd5, 32'h3002, 32'h00000001, 32'h00000001, 1'b1, 1'b1};

        // Reset: outputs zero even with a valid instruction offered
        ifc.flush = 1'b0; ifc.stall = '0; ifc.data_sram_rdata = 32'hFFFFFFFF;
        ifc.ex_to_mem_bus = {74'b0, exs(32'h10, 1'b1, 5'd1, 32'h1, 3'd0)};
        repeat (2) @(posedge clk);
        #2 check_zero("reset");
        @(negedge clk) rst = 1'b1;

        // Single-slot loads back to back, load data one cycle after issue
        for (int i = 0; i <= 15; i++) begin
            logic [147:0] ex;
            logic [31:0]  rd;
            ex = '0;
            rd = (i > 0) ? tbl[i-1].rd : 32'h0;
            if (i < 15) begin
                ex = {74'b0, exs(32'h1000_0000 + 32'(i*4), tbl[i].we, 5'(i+1), tbl[i].res, tbl[i].lop)};
                push1($sformatf("ld%0d", i), 32'h1000_0000 + 32'(i*4), tbl[i].we, 5'(i+1),
                      tbl[i].wd, tbl[i].adel);
            end
            cyc(ex, rd, '0, 1'b0);
        end

        // lhu held across a 3-cycle stall while rdata changes underneath
        push1("lhu_stall0", 32'h200, 1'b1, 5'd6, 32'h00009ABC, 1'b0);
        cyc({74'b0, exs(32'h200, 1'b1, 5'd6, 32'h2002, 3'd4)}, '0, '0, 1'b0);
        push1("lhu_stall1", 32'h200, 1'b1, 5'd6, 32'h00009ABC, 1'b0);
        cyc('0, 32'h9ABC1234, ST_HOLD, 1'b0);
        push1("lhu_stall2", 32'h200, 1'b1, 5'd6, 32'h00009ABC, 1'b0);
        cyc('0, 32'hDEADBEEF, ST_HOLD, 1'b0);
        push1("lhu_stall3", 32'h200, 1'b1, 5'd6, 32'h00009ABC, 1'b0);
        cyc('0, 32'hDEADBEEF, ST_HOLD, 1'b0);
        pushz("after_stall", cyc_n + 1);
        cyc('0, 32'hDEADBEEF, '0, 1'b0);

        // Dual issue; slot2 carries an lb op that must be ignored
        begin
            exp_t e;
            e.due = cyc_n + 1; e.tag = "dual";
            e.wb  = {wbs(32'h404, 1'b1, 5'd4, 32'h22), wbs(32'h400, 1'b1, 5'd3, 32'h11)};
            e.rf  = {1'b1, 5'd4, 32'h22, 1'b1, 5'd3, 32'h11};
            e.adel = 1'b0; e.epc = '0;
            q.push_back(e);
            cyc({exs(32'h404, 1'b1, 5'd4, 32'h22, 3'd1), exs(32'h400, 1'b1, 5'd3, 32'h11, 3'd0)},
                '0, '0, 1'b0);
        end

        // Bubble (MEM stalled, WB free), then flush beating a load
        push1("pre_bubble", 32'h500, 1'b1, 5'd9, 32'h55, 1'b0);
        cyc({74'b0, exs(32'h500, 1'b1, 5'd9, 32'h55, 3'd0)}, 32'hFFFFFFFF, '0, 1'b0);
        pushz("bubble", cyc_n + 1);
        cyc({74'b0, exs(32'h504, 1'b1, 5'd10, 32'h66, 3'd0)}, 32'hFFFFFFFF, ST_BUBBLE, 1'b0);
        push1("pre_flush", 32'h508, 1'b1, 5'd11, 32'h77, 1'b0);
        cyc({74'b0, exs(32'h508, 1'b1, 5'd11, 32'h77, 3'd0)}, 32'hFFFFFFFF, '0, 1'b0);
        pushz("flush", cyc_n + 1);
        cyc({exs(32'h510, 1'b1, 5'd2, 32'h1, 3'd0), exs(32'h50C, 1'b1, 5'd12, 32'h88, 3'd0)},
            32'hFFFFFFFF, '0, 1'b1);
        cyc('0, '0, '0, 1'b0);

        // Asynchronous reset while a load is held in a stall
        push1("rst_ld0", 32'h700, 1'b1, 5'd12, 32'h00001234, 1'b0);
        cyc({74'b0, exs(32'h700, 1'b1, 5'd12, 32'h2000, 3'd4)}, '0, '0, 1'b0);
        push1("rst_ld1", 32'h700, 1'b1, 5'd12, 32'h00001234, 1'b0);
        cyc('0, 32'h56781234, ST_HOLD, 1'b0);
        cyc('0, 32'hFFFF0000, ST_HOLD, 1'b0);
        #1 rst = 1'b0;
        #1 check_zero("async_rst");
        @(negedge clk) rst = 1'b1;
        pushz("post_rst0", cyc_n);
        cyc('0, 32'hAAAA5555, ST_HOLD, 1'b0);
        pushz("post_rst1", cyc_n + 1);
        cyc('0, 32'hAAAA5555, ST_HOLD, 1'b0);
        push1("post_rst_ld", 32'h800, 1'b1, 5'd13, 32'h0000BEEF, 1'b0);
        cyc({74'b0, exs(32'h800, 1'b1, 5'd13, 32'h2002, 3'd4)}, 32'hAAAA5555, '0, 1'b0);
        cyc('0, 32'hBEEF0000, '0, 1'b0);

        // Drain and confirm every expectation was consumed
        repeat (2) cyc('0, '0, '0, 1'b0);
        check("sb_empty", 140'(q.size()), 140'(0));

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/mem_stage.md
MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 Parameter STALL_WD, default 6, SHALL set the width of the stall bus; bit 3 is the MEM stage and bit 4 is the WB stage.
REQ-002 clk  in  1  SHALL be the single clock; all state SHALL be updated on its rising edge.
REQ-003 rst  in  1  SHALL be an asynchronous, active-low reset.
REQ-004 flush  in  1  SHALL be a pipeline flush with priority over stall.
REQ-005 stall  in  STALL_WD  SHALL be the stall vector; 1 = Stop.
REQ-006 ex_to_mem_bus  in  148  SHALL carry two 74-bit slots, slot2 at [147:74] and slot1 at [73:0].
  - Each slot is {valid[73], pc[72:41], we[40], waddr[39:35], result[34:3], load_op[2:0]}.
  - load_op encoding: 0 none, 1 lb, 2 lbu, 3 lh, 4 lhu, 5 lw; 6 and 7 are treated as none.
REQ-007 data_sram_rdata  in  32  SHALL be the load data returned one cycle after the EX-stage request.
REQ-008 mem_to_wb_bus  out  140  SHALL carry two 70-bit slots, slot2 at [139:70] and slot1 at [69:0]; each slot is {valid, pc, we, waddr, wdata}.
REQ-009 mem_to_rf_bus  out  76  SHALL carry two 38-bit forwarding slots, slot2 at [75:38] and slot1 at [37:0]; each slot is {we, waddr, wdata}.
REQ-010 excp_adel  out  1  SHALL flag a misaligned slot1 load.
REQ-011 excp_pc  out  32  SHALL hold the pc of the slot1 load flagged by excp_adel.

Function
REQ-012 The block SHALL register ex_to_mem_bus into bus_r; updates are evaluated in priority order below.
  - flush: clear bus_r.
  - stall[3]=1 and stall[4]=0: clear bus_r (bubble).
  - stall[3]=0: load bus_r.
  - otherwise: hold bus_r.
REQ-013 An invalid slot SHALL drive zero on every field of both output buses.
REQ-014 Only slot1 SHALL perform loads; slot2 load_op SHALL be ignored, so slot2 wdata = result.
REQ-015 Slot1 load data SHALL be taken from data_sram_rdata on the first cycle bus_r holds a new instruction, and from rdata_hold on later stalled cycles.
REQ-016 rdata_hold SHALL capture data_sram_rdata in that first cycle; a 1-bit hold_vld flag SHALL be set then and cleared whenever bus_r is reloaded, bubbled or flushed.
REQ-017 Byte select SHALL use result[1:0], with byte n = bits [8n+7:8n]; halfword select SHALL use result[1], with low = [15:0] and high = [31:16].
REQ-018 Sign and zero extension:
  - lb sign-extends the selected byte; lbu zero-extends it.
  - lh sign-extends the selected halfword; lhu zero-extends it.
  - lw passes all 32 bits.
REQ-019 Slot1 wdata SHALL equal result when load_op is none.
REQ-020 A lh/lhu with result[0]=1, or a lw with result[1:0]!=0, SHALL raise excp_adel and set excp_pc to the slot pc in the same cycle.
  - Such a load SHALL force slot1 we=0 on both output buses.
REQ-021 All outputs SHALL be combinational from bus_r, rdata_hold, hold_vld and data_sram_rdata, with zero added latency inside MEM.
REQ-022 mem_to_rf_bus SHALL present the same we, waddr and wdata as mem_to_wb_bus in the same cycle.
REQ-023 If flush and stall[3]=0 occur together, flush SHALL win and bus_r SHALL be zero next cycle.

Reset
REQ-024 rst=0 SHALL asynchronously clear bus_r, rdata_hold and hold_vld.
REQ-025 While rst=0, mem_to_wb_bus, mem_to_rf_bus, excp_adel and excp_pc SHALL all be 0.
REQ-026 Reset asserted mid-stall SHALL discard held load data; the first cycle after release SHALL present a bubble.

Verification
REQ-027 Slot1 lb with result=0x1003, rdata=0x80AA55CC, no stall -> slot1 wdata=0xFFFFFF80, we as issued, next cycle.
REQ-028 Slot1 lhu with result=0x2002, rdata=0x9ABC1234; stall[3]=1 for 3 cycles while rdata changes to 0xDEADBEEF -> wdata stays 0x00009ABC on all 4 cycles.
REQ-029 Slot1 lw with result=0x3001 -> excp_adel=1, excp_pc=slot pc, slot1 we=0 on both output buses.
REQ-030 Dual issue, slot1 ALU result=0x11 to r3 and slot2 result=0x22 to r4 -> both buses show we=1, waddr 3/4, wdata 0x11/0x22 simultaneously.
REQ-031 stall[3]=1, stall[4]=0 -> next cycle outputs are all zero; flush asserted together with stall[3]=0 -> outputs are zero.
REQ-032 rst driven 0 asynchronously mid-cycle with a valid load held -> outputs go to 0 immediately; after release the output is a bubble until a new instruction enters.
